// File: rtl/io_trap_unit_pkg.sv
// Shared definitions for the Z80 I/O trap unit.
// State encoding, mapper nibble, status bits, capture record.
package io_trap_unit_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_PULSE   = 2'd2;
  localparam logic [1:0] ST_PENDING = 2'd3;

  localparam logic [3:0] MAP_NIBBLE = 4'h2;

  localparam int STAT_PENDING_BIT = 0;
  localparam int STAT_OVERRUN_BIT = 1;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       dir;
  } trap_rec_t;

  localparam trap_rec_t TRAP_REC_RST = '{
    addr: 8'h00,
    data: 8'hFF,
    dir:  1'b0
  };

  // The mapper's own port range can never be trapped.
  function automatic logic nib_hit(
    input logic [7:0] a,
    input logic [3:0] nib
  );
    return (a[7:4] == nib) &&
           (a[7:4] != MAP_NIBBLE);
  endfunction

endpackage

// File: rtl/io_trap_unit_if.sv
// Z80 I/O bus bundle seen by the trap unit.
// master = CPU side, slave = trap unit.
interface io_trap_unit_if;
  import io_trap_unit_pkg::*;

  logic [7:0] addr;
  logic [7:0] data_in;
  logic       iorq_n;
  logic       m1_n;
  logic       rd_n;
  logic       wr_n;
  logic       iorq_sys_n;

  modport master (
    output addr, data_in,
    output iorq_n, m1_n, rd_n, wr_n,
    input  iorq_sys_n
  );

  modport slave (
    input  addr, data_in,
    input  iorq_n, m1_n, rd_n, wr_n,
    output iorq_sys_n
  );

endinterface

// File: rtl/io_trap_unit_nmi.sv
// NMI pulse generator: nmi_n low for i_width clocks after i_start.
// o_last flags the final low cycle so the owner can move on in step.
module nmi_pulse_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [3:0] i_width,
  output logic       o_nmi_n,
  output logic       o_last
);

  logic [3:0] r_cnt;
  logic       r_nmi_n;
  logic [3:0] w_load;

  // A zero width would leave nmi_n stuck low.
  assign w_load = (i_width == 4'd0) ? 4'd1 : i_width;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_nmi_n <= 1'b1;
    end else if (i_start) begin
      r_cnt   <= w_load;
      r_nmi_n <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1)
        r_nmi_n <= 1'b1;
    end
  end

  assign o_nmi_n = r_nmi_n;
  assign o_last  = (r_cnt == 4'd1);

endmodule

// File: rtl/io_trap_unit.sv
// Z80 I/O trap: hides trapped port cycles from the system bus,
// latches the access and raises an NMI for the mapper's handler.
module io_trap_unit
  import io_trap_unit_pkg::*;
#(
  parameter logic [3:0] TRAP_NIBBLE = 4'hA,
  parameter int         NMI_WIDTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  io_trap_unit_if.slave  bus,
  input  logic           trap_en,
  input  logic           trap_ack,
  output logic           nmi_n,
  output logic [7:0]     trap_addr,
  output logic [7:0]     trap_data,
  output logic           trap_dir,
  output logic           trap_pending,
  output logic           trap_overrun
);

  localparam logic [3:0] W_WIDTH = 4'(NMI_WIDTH);

  logic       r_iorq_q;
  logic [1:0] r_state;
  trap_rec_t  r_rec;
  logic       r_ovr;

  logic       w_hit;
  logic       w_hit_edge;
  logic       w_ack;
  logic       w_cap;
  logic       w_start;
  logic       w_last;
  logic       w_nmi_n;
  trap_rec_t  w_rec;
  logic       w_unused_rd;

  assign w_unused_rd = bus.rd_n;

  assign w_hit = !bus.iorq_n && bus.m1_n &&
                 trap_en &&
                 nib_hit(bus.addr, TRAP_NIBBLE);

  assign bus.iorq_sys_n = bus.iorq_n | w_hit;

  assign w_hit_edge = w_hit & r_iorq_q;
  assign w_ack      = trap_ack &&
                      (r_state == ST_PENDING);
  // An ack in PENDING frees the slot for a same-edge hit.
  assign w_cap      = w_hit_edge &&
                      ((r_state == ST_IDLE) || w_ack);
  assign w_start    = (r_state == ST_CAPTURE) &&
                      bus.iorq_n;

  always_comb begin
    w_rec      = TRAP_REC_RST;
    w_rec.addr = bus.addr;
    w_rec.dir  = !bus.wr_n;
    w_rec.data = bus.wr_n ? 8'hFF : bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_iorq_q <= 1'b1;
    else
      r_iorq_q <= bus.iorq_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_hit_edge)
            r_state <= ST_CAPTURE;
        ST_CAPTURE:
          if (bus.iorq_n)
            r_state <= ST_PULSE;
        ST_PULSE:
          if (w_last)
            r_state <= ST_PENDING;
        ST_PENDING:
          if (w_ack)
            r_state <= w_hit_edge ?
                       ST_CAPTURE : ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rec <= TRAP_REC_RST;
      r_ovr <= 1'b0;
    end else if (w_cap) begin
      r_rec <= w_rec;
      r_ovr <= 1'b0;
    end else if (w_ack) begin
      r_ovr <= 1'b0;
    end else if (w_hit_edge) begin
      r_ovr <= 1'b1;
    end
  end

  nmi_pulse_gen u_nmi (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_width (W_WIDTH),
    .o_nmi_n (w_nmi_n),
    .o_last  (w_last)
  );

  assign nmi_n        = w_nmi_n;
  assign trap_addr    = r_rec.addr;
  assign trap_data    = r_rec.data;
  assign trap_dir     = r_rec.dir;
  assign trap_pending = (r_state != ST_IDLE);
  assign trap_overrun = r_ovr;

endmodule

// File: tb/tb_io_trap_unit.sv
// Self-checking bench for io_trap_unit.
// Directed cases plus random bus traffic against a cycle model.
module tb_io_trap_unit;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trap_en = 1'b0;
  logic       trap_ack = 1'b0;
  logic       nmi_n;
  logic [7:0] trap_addr;
  logic [7:0] trap_data;
  logic       trap_dir;
  logic       trap_pending;
  logic       trap_overrun;

  io_trap_unit_if bus();

  io_trap_unit #(
    .TRAP_NIBBLE (4'hA),
    .NMI_WIDTH   (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .trap_en      (trap_en),
    .trap_ack     (trap_ack),
    .nmi_n        (nmi_n),
    .trap_addr    (trap_addr),
    .trap_data    (trap_data),
    .trap_dir     (trap_dir),
    .trap_pending (trap_pending),
    .trap_overrun (trap_overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding trap record,
  // a "waiting for iorq release" flag and NMI cycles left.
  bit         m_busy;
  bit         m_wait;
  int         m_left;
  bit         m_ovr;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  bit         m_dir;
  bit         m_prev_iorq;

  function automatic bit hit_now();
    return !bus.iorq_n && bus.m1_n && trap_en &&
           bus.addr >= 8'hA0 && bus.addr <= 8'hAF;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_wait = 0;
    m_left = 0;
    m_ovr = 0;
    m_addr = 8'h00;
    m_data = 8'hFF;
    m_dir = 0;
    m_prev_iorq = 1;
  endtask

  task automatic model_edge();
    bit e;
    bit ack_ok;
    e = hit_now() && m_prev_iorq;
    ack_ok = m_busy && !m_wait && m_left == 0 &&
             trap_ack;
    if (!m_busy || ack_ok) begin
      m_busy = 0;
      m_ovr = 0;
      if (e) begin
        m_busy = 1;
        m_wait = 1;
        m_addr = bus.addr;
        m_dir = !bus.wr_n;
        m_data = m_dir ? bus.data_in : 8'hFF;
      end
    end else begin
      if (e) m_ovr = 1;
      if (m_wait) begin
        if (bus.iorq_n) begin
          m_wait = 0;
          m_left = W;
        end
      end else if (m_left > 0) begin
        m_left--;
      end
    end
    m_prev_iorq = bus.iorq_n;
  endtask

  task automatic compare_all();
    chk("iorq_sys", bus.iorq_sys_n,
        bus.iorq_n || hit_now());
    chk("nmi", nmi_n, (m_left > 0) ? 0 : 1);
    chk("pending", trap_pending, m_busy);
    chk("overrun", trap_overrun, m_ovr);
    chk("addr", trap_addr, m_addr);
    chk("data", trap_data, m_data);
    chk("dir", trap_dir, m_dir);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1;
    bus.m1_n = 1;
    bus.rd_n = 1;
    bus.wr_n = 1;
  endtask

  task automatic io_cycle(
    input logic [7:0] a,
    input logic [7:0] d,
    input bit         wr,
    input int         nlow
  );
    bus.addr = a;
    bus.data_in = d;
    bus.wr_n = !wr;
    bus.rd_n = wr;
    bus.iorq_n = 0;
    repeat (nlow) step();
    bus_idle();
    step();
  endtask

  task automatic ack_pulse();
    trap_ack = 1;
    step();
    trap_ack = 0;
  endtask

  initial begin
    bus_idle();
    bus.addr = 8'h00;
    bus.data_in = 8'h00;
    model_reset();
    repeat (2) step();
    chk("rst_nmi", nmi_n, 1);
    chk("rst_pend", trap_pending, 0);
    chk("rst_ovr", trap_overrun, 0);
    chk("rst_addr", trap_addr, 8'h00);
    chk("rst_data", trap_data, 8'hFF);
    chk("rst_dir", trap_dir, 0);
    reset = 0;
    step();

    // OUT (0xA1),0x5A trapped, NMI low for W clocks
    trap_en = 1;
    io_cycle(8'hA1, 8'h5A, 1, 2);
    chk("out_nmi_lo", nmi_n, 0);
    chk("out_addr", trap_addr, 8'hA1);
    chk("out_data", trap_data, 8'h5A);
    chk("out_dir", trap_dir, 1);
    repeat (W - 1) step();
    chk("out_nmi_last", nmi_n, 0);
    step();
    chk("out_nmi_hi", nmi_n, 1);
    chk("out_pend", trap_pending, 1);

    // second hit before ack -> overrun only
    io_cycle(8'hA8, 8'h11, 1, 1);
    chk("ovr_set", trap_overrun, 1);
    chk("ovr_addr", trap_addr, 8'hA1);
    chk("ovr_nmi", nmi_n, 1);
    ack_pulse();
    chk("ack_pend", trap_pending, 0);
    chk("ack_ovr", trap_overrun, 0);

    // trapped read, then ack coincident with new hit
    io_cycle(8'hA3, 8'h00, 0, 1);
    repeat (W) step();
    chk("rd_data", trap_data, 8'hFF);
    chk("rd_dir", trap_dir, 0);
    io_cycle(8'hA4, 8'h33, 1, 1);
    chk("pre_ovr", trap_overrun, 1);
    bus.addr = 8'hA2;
    bus.data_in = 8'h77;
    bus.wr_n = 0;
    bus.iorq_n = 0;
    trap_ack = 1;
    step();
    trap_ack = 0;
    chk("coin_addr", trap_addr, 8'hA2);
    chk("coin_ovr", trap_overrun, 0);
    chk("coin_pend", trap_pending, 1);
    chk("coin_data", trap_data, 8'h77);
    bus_idle();
    step();
    repeat (W) step();
    ack_pulse();

    // trap disabled: IN A,(0xA0) passes through
    trap_en = 0;
    bus.addr = 8'hA0;
    bus.rd_n = 0;
    bus.iorq_n = 0;
    step();
    chk("dis_sys", bus.iorq_sys_n, 0);
    chk("dis_pend", trap_pending, 0);
    bus_idle();
    step();
    trap_en = 1;

    // interrupt acknowledge passes through
    bus.m1_n = 0;
    bus.addr = 8'hA0;
    bus.iorq_n = 0;
    step();
    chk("inta_sys", bus.iorq_sys_n, 0);
    chk("inta_pend", trap_pending, 0);
    bus_idle();
    step();

    // reset during the second NMI clock
    io_cycle(8'hA5, 8'h42, 1, 1);
    step();
    chk("pre_rst_nmi", nmi_n, 0);
    reset = 1;
    model_reset();
    #1;
    chk("arst_nmi", nmi_n, 1);
    chk("arst_pend", trap_pending, 0);
    chk("arst_ovr", trap_overrun, 0);
    chk("arst_addr", trap_addr, 8'h00);
    step();
    reset = 0;
    step();

    // random traffic
    for (int i = 0; i < 250; i++) begin
      int r;
      trap_en = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 9);
      if (r < 6)
        bus.addr = {4'hA, 4'($urandom_range(0, 15))};
      else if (r < 8)
        bus.addr = {4'h2, 4'($urandom_range(0, 15))};
      else
        bus.addr = 8'($urandom_range(0, 255));
      bus.data_in = 8'($urandom_range(0, 255));
      bus.m1_n = ($urandom_range(0, 9) != 0);
      bus.wr_n = 1'($urandom_range(0, 1));
      bus.rd_n = !bus.wr_n;
      bus.iorq_n = 0;
      trap_ack = ($urandom_range(0, 3) == 0);
      step();
      trap_ack = 0;
      repeat ($urandom_range(0, 2)) step();
      bus_idle();
      step();
      repeat ($urandom_range(0, 6)) begin
        trap_ack = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0)
          trap_en = !trap_en;
        step();
        trap_ack = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
